dmem_lsu_rv32: RTL and testbench
================================

# dmem_lsu_rv32

Load/store unit for the RV32I data-memory path, between the execute stage and the memory-access stage. It takes one memory instruction at a time and drives a request/grant/valid data-memory bus with byte enables and lane-replicated store data. It extracts and sign- or zero-extends load data, and generates the pipeline stall that the memory-access stage consumes as its data-cache stall input. It also flags misaligned accesses and bus timeouts instead of hanging the pipeline.

## Interface
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before a transaction is aborted; range 1..65535.
- iCLK  in  1  clock.
- iRST  in  1  reset; synchronous, active-high.
- iMEM  in  1  a memory instruction is present this cycle.
- iRW  in  1  1 = read (load), 0 = write (store).
- iDecodedOP  in  5  operation code: `LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW` from DecodedOP.vh.
- iADDR  in  32  effective byte address from execute.
- iWDATA  in  32  store data (rs2).
- oMemReq  out  1  bus request; held until granted.
- oMemWE  out  1  1 = write transaction.
- oMemADDR  out  32  word-aligned address, i.e. the captured address with bits [1:0] forced to 00.
- oMemBE  out  4  byte enables.
- oMemWDATA  out  32  lane-replicated store data.
- iMemGnt  in  1  bus accepted the request this cycle.
- iMemValid  in  1  read data valid; sampled only in WAIT.
- iMemRDATA  in  32  read data word.
- oStallD  out  1  stall to upstream and to the memory-access stage.
- oLoadDATA  out  32  extended load result.
- oLoadValid  out  1  one-cycle pulse; oLoadDATA is valid.
- oMisaligned  out  1  one-cycle pulse; access was misaligned and not issued.
- oBusErr  out  1  one-cycle pulse; transaction timed out.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **Accept (IDLE with iMEM=1).** The unit captures iRW, iDecodedOP, iADDR and iWDATA, so upstream need not hold them.
  - Aligned access: go to REQ.
  - Misaligned access: go to DONE with oMisaligned=1 and no bus activity.
  - Misaligned means an H-type access with addr[0]=1, or a W-type access with addr[1:0]≠00.
  - An opcode that does not match iRW (for example a store code with iRW=1) is treated as a no-op: DONE, no flags.
- **REQ.** oMemReq=1, with all bus outputs stable. On iMemGnt:
  - store: go to DONE;
  - load: go to WAIT.
- **WAIT.** On iMemValid, register the extended data into oLoadDATA and go to DONE with oLoadValid=1.
- **DONE.** Always returns to IDLE. An instruction present during DONE is the one just completed and is never re-accepted.
- **Timeout.** A counter clears on accept and increments in REQ and WAIT. When it reaches TIMEOUT_CYCLES, the unit goes to DONE with oBusErr=1, oLoadDATA=0 and oMemReq dropped.
- **Store byte enables and data:**
  - SB: BE = 0001 shifted left by addr[1:0]; WDATA = byte replicated ×4.
  - SH: BE = 0011 (addr[1]=0) or 1100 (addr[1]=1); WDATA = halfword replicated ×2.
  - SW: BE = 1111; WDATA unchanged.
- **Load extraction:** shift the data word right by 8×addr[1:0], then:
  - LB/LH sign-extend bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes through.
- oMemBE and oMemWE are driven for loads too: BE per size, WE=0.
- iMemValid outside WAIT is ignored. This covers late data after a timeout or a reset.

## Timing
- **Reset values:** state IDLE, counter 0, all outputs 0, including oStallD and oMemReq.
- **oStallD** is combinational:
  - 1 in IDLE when iMEM=1;
  - 1 in REQ and WAIT;
  - 0 in DONE and in an idle IDLE.
- All other outputs are registered.
- **Store latency.** Accept at cycle 0, REQ at cycle 1; with iMemGnt at cycle 1, DONE at cycle 2. Stall is high for cycles 0–1.
- **Load latency.** Accept at 0, REQ at 1 (granted), WAIT at 2 (valid), DONE at 3 with oLoadValid=1. Stall is high for cycles 0–2.
- Each grant delay or valid delay adds one stall cycle per cycle of delay.
- **Misaligned access.** Accept at 0, DONE at 1 with oMisaligned=1. One stall cycle.
- Pulses (oLoadValid, oMisaligned, oBusErr) are high only in DONE.
- oLoadDATA holds its value until the next load completes or an error occurs.
- **Reset mid-transaction.** The next edge returns the unit to IDLE with oMemReq=0. Any pending response is discarded.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, immediate grant -> oMemADDR=0x100, BE=1111, WE=1, stall for 2 cycles, DONE at cycle 2.
- SB to 0x103 with data 0x000000A5 -> BE=1000, WDATA=0xA5A5A5A5; SH to 0x102 with data 0x1234 -> BE=1100, WDATA=0x12341234.
- LB at 0x201 with iMemRDATA=0x00008000, grant delayed 2 cycles and valid 1 cycle after grant -> oLoadDATA=0xFFFFFF80; LBU at 0x201 -> 0x00000080; LHU at 0x202 with 0xBEEF0000 -> 0x0000BEEF.
- LW at 0x102 -> no oMemReq, oMisaligned pulse at cycle 1, one stall cycle; LH at 0x101 -> same behaviour.
- TIMEOUT_CYCLES=4, LW never granted -> oBusErr pulses after 4 REQ cycles and oLoadDATA=0; a late iMemValid is then ignored.
- iRST asserted in WAIT -> next cycle oMemReq=0, oStallD=0; a following SW completes normally.

Source files
------------

// File: rtl/dmem_lsu_rv32.sv
// -----------------------------------------------------------------------------
// dmem_lsu_rv32 - RV32I load/store unit for the data-memory path.
//
// Takes one memory instruction at a time from execute, captures it, and drives
// a request/grant/valid data-memory bus. Stores get byte enables and
// lane-replicated data. Loads get their result extracted from the returned
// word and sign- or zero-extended. Misaligned accesses and bus timeouts
// complete with a one-cycle flag instead of hanging the pipeline.
//
// Ports
//   iCLK, iRST        clock; synchronous active-high reset
//   iMEM              memory instruction present this cycle
//   iRW               1 = load, 0 = store
//   iDecodedOP[4:0]   LB/LH/LW/LBU/LHU/SB/SH/SW operation code
//   iADDR[31:0]       effective byte address
//   iWDATA[31:0]      store data (rs2)
//   oMemReq           bus request, held until iMemGnt
//   oMemWE            1 = write transaction
//   oMemADDR[31:0]    word-aligned bus address
//   oMemBE[3:0]       byte enables (driven for loads and stores)
//   oMemWDATA[31:0]   lane-replicated store data
//   iMemGnt           bus accepted the request
//   iMemValid         read data valid (sampled only in WAIT)
//   iMemRDATA[31:0]   read data word
//   oStallD           combinational stall to upstream / memory-access stage
//   oLoadDATA[31:0]   extended load result, held until next load or error
//   oLoadValid        one-cycle pulse, oLoadDATA updated
//   oMisaligned       one-cycle pulse, access rejected as misaligned
//   oBusErr           one-cycle pulse, transaction timed out
// -----------------------------------------------------------------------------
module dmem_lsu_rv32 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMEM,
    input  logic        iRW,
    input  logic [4:0]  iDecodedOP,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    output logic        oMemReq,
    output logic        oMemWE,
    output logic [31:0] oMemADDR,
    output logic [3:0]  oMemBE,
    output logic [31:0] oMemWDATA,
    input  logic        iMemGnt,
    input  logic        iMemValid,
    input  logic [31:0] iMemRDATA,
    output logic        oStallD,
    output logic [31:0] oLoadDATA,
    output logic        oLoadValid,
    output logic        oMisaligned,
    output logic        oBusErr
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned CNT_W = 16;

    // Operation codes (DecodedOP encoding)
    localparam logic [OP_W-1:0] OP_LB  = 5'd0;
    localparam logic [OP_W-1:0] OP_LH  = 5'd1;
    localparam logic [OP_W-1:0] OP_LW  = 5'd2;
    localparam logic [OP_W-1:0] OP_LBU = 5'd3;
    localparam logic [OP_W-1:0] OP_LHU = 5'd4;
    localparam logic [OP_W-1:0] OP_SB  = 5'd5;
    localparam logic [OP_W-1:0] OP_SH  = 5'd6;
    localparam logic [OP_W-1:0] OP_SW  = 5'd7;

    // Last counter value before the abort; the counter is 0 in the first REQ cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              rw_q, rw_d;
    logic [1:0]        lane_q, lane_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              misal_q, misal_d;
    logic              bus_err_q, bus_err_d;

    // Decode of the incoming instruction
    logic              acc_load_c, acc_store_c, acc_half_c, acc_word_c;
    logic              acc_match_c, acc_misal_c;
    logic [3:0]        acc_be_c;
    logic [31:0]       acc_wdata_c;

    // Load data path
    logic [31:0]       rd_shift_c;
    logic [31:0]       rd_ext_c;

    // Classify the incoming operation and build its bus byte enables / data.
    always_comb begin
        acc_load_c  = 1'b0;
        acc_store_c = 1'b0;
        acc_half_c  = 1'b0;
        acc_word_c  = 1'b0;
        unique case (iDecodedOP)
            OP_LB, OP_LBU: acc_load_c = 1'b1;
            OP_LH, OP_LHU: begin acc_load_c  = 1'b1; acc_half_c = 1'b1; end
            OP_LW:         begin acc_load_c  = 1'b1; acc_word_c = 1'b1; end
            OP_SB:         acc_store_c = 1'b1;
            OP_SH:         begin acc_store_c = 1'b1; acc_half_c = 1'b1; end
            OP_SW:         begin acc_store_c = 1'b1; acc_word_c = 1'b1; end
            default:       ;
        endcase

        // A code that disagrees with iRW (or is unknown) completes as a no-op.
        acc_match_c = iRW ? acc_load_c : acc_store_c;
        acc_misal_c = (acc_half_c && iADDR[0]) ||
                      (acc_word_c && (iADDR[1:0] != 2'b00));

        if (acc_word_c) begin
            acc_be_c = 4'b1111;
        end else if (acc_half_c) begin
            acc_be_c = iADDR[1] ? 4'b1100 : 4'b0011;
        end else begin
            acc_be_c = 4'b0001 << iADDR[1:0];
        end

        if (!acc_store_c || acc_word_c) begin
            acc_wdata_c = acc_store_c ? iWDATA : 32'h0;
        end else if (acc_half_c) begin
            acc_wdata_c = {2{iWDATA[15:0]}};
        end else begin
            acc_wdata_c = {4{iWDATA[7:0]}};
        end
    end

    // Move the addressed byte/halfword down to bit 0, then extend per opcode.
    assign rd_shift_c = iMemRDATA >> {lane_q, 3'b000};

    always_comb begin
        rd_ext_c = rd_shift_c;
        unique case (op_q)
            OP_LB:   rd_ext_c = {{24{rd_shift_c[7]}},  rd_shift_c[7:0]};
            OP_LH:   rd_ext_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            OP_LBU:  rd_ext_c = {24'h0, rd_shift_c[7:0]};
            OP_LHU:  rd_ext_c = {16'h0, rd_shift_c[15:0]};
            default: rd_ext_c = rd_shift_c;
        endcase
    end

    // State register and all registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            rw_q         <= 1'b0;
            lane_q       <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misal_q      <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rw_q         <= rw_d;
            lane_q       <= lane_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misal_q      <= misal_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rw_d         = rw_q;
        lane_d       = lane_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misal_d      = 1'b0;
        bus_err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (iMEM) begin
                    cnt_d  = '0;
                    op_d   = iDecodedOP;
                    rw_d   = iRW;
                    lane_d = iADDR[1:0];
                    if (!acc_match_c) begin
                        state_d = S_DONE;
                    end else if (acc_misal_c) begin
                        state_d = S_DONE;
                        misal_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~iRW;
                        mem_addr_d  = {iADDR[31:2], 2'b00};
                        mem_be_d    = acc_be_c;
                        mem_wdata_d = acc_wdata_c;
                    end
                end
            end

            // A grant arriving in the last allowed cycle still wins over the abort.
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (iMemGnt) begin
                    state_d = rw_q ? S_WAIT : S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (iMemValid) begin
                    state_d      = S_DONE;
                    load_valid_d = 1'b1;
                    load_data_d  = rd_ext_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end

            // The instruction seen here is the one just finished; never re-accept it.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Stall covers the accept cycle and every bus cycle, but not DONE.
    always_comb begin
        oStallD = 1'b0;
        unique case (state_q)
            S_IDLE:  oStallD = iMEM;
            S_REQ,
            S_WAIT:  oStallD = 1'b1;
            default: oStallD = 1'b0;
        endcase
    end

    assign oMemReq     = mem_req_q;
    assign oMemWE      = mem_we_q;
    assign oMemADDR    = mem_addr_q;
    assign oMemBE      = mem_be_q;
    assign oMemWDATA   = mem_wdata_q;
    assign oLoadDATA   = load_data_q;
    assign oLoadValid  = load_valid_q;
    assign oMisaligned = misal_q;
    assign oBusErr     = bus_err_q;

endmodule

// File: tb/tb_dmem_lsu_rv32.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu_rv32 - directed bench for dmem_lsu_rv32.
// Main instance uses the default timeout; a second instance with
// TIMEOUT_CYCLES=4 shares the inputs and is observed only for the timeout case.
// Inputs are driven 1 ns after the rising edge and outputs are checked 1 ns
// later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_dmem_lsu_rv32;

    localparam logic [4:0] OP_LB  = 5'd0;
    localparam logic [4:0] OP_LH  = 5'd1;
    localparam logic [4:0] OP_LW  = 5'd2;
    localparam logic [4:0] OP_LBU = 5'd3;
    localparam logic [4:0] OP_LHU = 5'd4;
    localparam logic [4:0] OP_SB  = 5'd5;
    localparam logic [4:0] OP_SH  = 5'd6;
    localparam logic [4:0] OP_SW  = 5'd7;

    logic        iCLK = 1'b0;
    logic        iRST, iMEM, iRW, iMemGnt, iMemValid;
    logic [4:0]  iDecodedOP;
    logic [31:0] iADDR, iWDATA, iMemRDATA;

    logic        mem_req, mem_we, stall, load_valid, misal, bus_err;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;

    logic        t_req, t_we, t_stall, t_load_valid, t_misal, t_bus_err;
    logic [31:0] t_addr, t_wdata, t_load_data;
    logic [3:0]  t_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 iCLK = ~iCLK;

    dmem_lsu_rv32 dut (
        .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW),
        .iDecodedOP(iDecodedOP), .iADDR(iADDR), .iWDATA(iWDATA),
        .oMemReq(mem_req), .oMemWE(mem_we), .oMemADDR(mem_addr),
        .oMemBE(mem_be), .oMemWDATA(mem_wdata),
        .iMemGnt(iMemGnt), .iMemValid(iMemValid), .iMemRDATA(iMemRDATA),
        .oStallD(stall), .oLoadDATA(load_data), .oLoadValid(load_valid),
        .oMisaligned(misal), .oBusErr(bus_err)
    );

    dmem_lsu_rv32 #(.TIMEOUT_CYCLES(4)) dut_to (
        .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW),
        .iDecodedOP(iDecodedOP), .iADDR(iADDR), .iWDATA(iWDATA),
        .oMemReq(t_req), .oMemWE(t_we), .oMemADDR(t_addr),
        .oMemBE(t_be), .oMemWDATA(t_wdata),
        .iMemGnt(iMemGnt), .iMemValid(iMemValid), .iMemRDATA(iMemRDATA),
        .oStallD(t_stall), .oLoadDATA(t_load_data), .oLoadValid(t_load_valid),
        .oMisaligned(t_misal), .oBusErr(t_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_inputs();
        iMEM       = 1'b0;
        iRW        = 1'b0;
        iDecodedOP = 5'd0;
        iADDR      = 32'h0;
        iWDATA     = 32'h0;
        iMemGnt    = 1'b0;
        iMemValid  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        #1;
    endtask

    // Present one instruction in the current (IDLE) cycle; settles comb outputs.
    task automatic issue(input logic rw, input logic [4:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        iMEM       = 1'b1;
        iRW        = rw;
        iDecodedOP = op;
        iADDR      = addr;
        iWDATA     = wd;
        #1;
    endtask

    // Store with immediate grant: accept at 0, REQ at 1, DONE at 2.
    task automatic store_fast(input string tag, input logic [4:0] op,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd);
        issue(1'b0, op, addr, wd);
        chkb({tag, " stall c0"}, stall, 1'b1);
        tick();
        iMEM    = 1'b0;
        iMemGnt = 1'b1;
        #1;
        chkb({tag, " req c1"}, mem_req, 1'b1);
        chkb({tag, " we c1"}, mem_we, 1'b1);
        chk ({tag, " addr c1"}, mem_addr, exp_addr);
        chk ({tag, " be c1"}, 32'(mem_be), 32'(exp_be));
        chk ({tag, " wdata c1"}, mem_wdata, exp_wd);
        chkb({tag, " stall c1"}, stall, 1'b1);
        tick();
        iMemGnt = 1'b0;
        #1;
        chkb({tag, " req c2"}, mem_req, 1'b0);
        chkb({tag, " stall c2"}, stall, 1'b0);
        tick();
    endtask

    // Load with immediate grant and valid: accept 0, REQ 1, WAIT 2, DONE 3.
    task automatic load_fast(input string tag, input logic [4:0] op,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b1, op, addr, 32'h0);
        chkb({tag, " stall c0"}, stall, 1'b1);
        tick();
        iMEM    = 1'b0;
        iMemGnt = 1'b1;
        #1;
        chkb({tag, " req c1"}, mem_req, 1'b1);
        chkb({tag, " we c1"}, mem_we, 1'b0);
        chk ({tag, " be c1"}, 32'(mem_be), 32'(exp_be));
        tick();
        iMemGnt   = 1'b0;
        iMemValid = 1'b1;
        iMemRDATA = rdata;
        #1;
        chkb({tag, " stall c2"}, stall, 1'b1);
        chkb({tag, " req c2"}, mem_req, 1'b0);
        tick();
        iMemValid = 1'b0;
        #1;
        chkb({tag, " lvalid c3"}, load_valid, 1'b1);
        chk ({tag, " ldata c3"}, load_data, exp_data);
        chkb({tag, " stall c3"}, stall, 1'b0);
        tick();
    endtask

    // Misaligned or no-op access: DONE at cycle 1, no request.
    task automatic reject(input string tag, input logic rw, input logic [4:0] op,
                          input logic [31:0] addr, input logic exp_mis);
        issue(rw, op, addr, 32'h0);
        chkb({tag, " stall c0"}, stall, 1'b1);
        tick();
        iMEM = 1'b0;
        #1;
        chkb({tag, " mis c1"}, misal, exp_mis);
        chkb({tag, " req c1"}, mem_req, 1'b0);
        chkb({tag, " stall c1"}, stall, 1'b0);
        chkb({tag, " lvalid c1"}, load_valid, 1'b0);
        tick();
        #1;
        chkb({tag, " mis c2"}, misal, 1'b0);
    endtask

    initial begin
        clear_inputs();
        iMemRDATA = 32'h0;
        iRST = 1'b1;
        tick();
        tick();
        #1;
        chkb("rst req", mem_req, 1'b0);
        chkb("rst stall", stall, 1'b0);
        chkb("rst we", mem_we, 1'b0);
        chk ("rst addr", mem_addr, 32'h0);
        chk ("rst ldata", load_data, 32'h0);
        chkb("rst lvalid", load_valid, 1'b0);
        chkb("rst mis", misal, 1'b0);
        chkb("rst buserr", bus_err, 1'b0);
        iRST = 1'b0;
        tick();

        // Stores
        store_fast("sw100", OP_SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        store_fast("sb103", OP_SB, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        store_fast("sh102", OP_SH, 32'h0000_0102, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h1234_1234);
        store_fast("sb201", OP_SB, 32'h0000_0201, 32'h1234_5677, 32'h0000_0200, 4'b0010, 32'h7777_7777);

        // LB at 0x201 with grant delayed two cycles, valid one cycle after grant
        issue(1'b1, OP_LB, 32'h0000_0201, 32'h0);
        iMemRDATA = 32'h0000_8000;
        chkb("lbslow stall c0", stall, 1'b1);
        tick();
        iMEM = 1'b0;
        #1;
        chkb("lbslow req c1", mem_req, 1'b1);
        chk ("lbslow addr c1", mem_addr, 32'h0000_0200);
        chk ("lbslow be c1", 32'(mem_be), 32'h2);
        chkb("lbslow we c1", mem_we, 1'b0);
        tick();
        #1;
        chkb("lbslow req c2", mem_req, 1'b1);
        chkb("lbslow stall c2", stall, 1'b1);
        tick();
        iMemGnt = 1'b1;
        #1;
        chkb("lbslow req c3", mem_req, 1'b1);
        tick();
        iMemGnt   = 1'b0;
        iMemValid = 1'b1;
        #1;
        chkb("lbslow req c4", mem_req, 1'b0);
        chkb("lbslow stall c4", stall, 1'b1);
        tick();
        iMemValid = 1'b0;
        #1;
        chkb("lbslow lvalid c5", load_valid, 1'b1);
        chk ("lbslow ldata c5", load_data, 32'hFFFF_FF80);
        chkb("lbslow stall c5", stall, 1'b0);
        tick();
        #1;
        chkb("lbslow lvalid c6", load_valid, 1'b0);
        chk ("lbslow ldata hold", load_data, 32'hFFFF_FF80);

        load_fast("lbu201", OP_LBU, 32'h0000_0201, 32'h0000_8000, 4'b0010, 32'h0000_0080);
        load_fast("lhu202", OP_LHU, 32'h0000_0202, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF);
        load_fast("lh202",  OP_LH,  32'h0000_0202, 32'hBEEF_0000, 4'b1100, 32'hFFFF_BEEF);
        load_fast("lb203",  OP_LB,  32'h0000_0203, 32'h7F11_2233, 4'b1000, 32'h0000_007F);
        load_fast("lw200",  OP_LW,  32'h0000_0200, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Misaligned and mismatched accesses
        reject("lw102", 1'b1, OP_LW, 32'h0000_0102, 1'b1);
        reject("lh101", 1'b1, OP_LH, 32'h0000_0101, 1'b1);
        reject("sw101", 1'b0, OP_SW, 32'h0000_0101, 1'b1);
        reject("swrw1", 1'b1, OP_SW, 32'h0000_0100, 1'b0);
        chk("noop ldata hold", load_data, 32'h1234_5678);

        // Timeout on the TIMEOUT_CYCLES=4 instance; preload its oLoadDATA first
        do_reset();
        tick();
        load_fast("preto", OP_LW, 32'h0000_0300, 32'h1234_5678, 4'b1111, 32'h1234_5678);
        chk("preto t ldata", t_load_data, 32'h1234_5678);
        issue(1'b1, OP_LW, 32'h0000_0300, 32'h0);
        tick();
        iMEM = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chkb($sformatf("to req c%0d", c), t_req, 1'b1);
            chkb($sformatf("to buserr c%0d", c), t_bus_err, 1'b0);
            tick();
        end
        #1;
        chkb("to buserr c5", t_bus_err, 1'b1);
        chkb("to req c5", t_req, 1'b0);
        chk ("to ldata c5", t_load_data, 32'h0);
        chkb("to stall c5", t_stall, 1'b0);
        tick();
        iMemValid = 1'b1;
        iMemRDATA = 32'hCAFE_F00D;
        #1;
        chkb("to buserr c6", t_bus_err, 1'b0);
        tick();
        iMemValid = 1'b0;
        #1;
        chkb("to late lvalid", t_load_valid, 1'b0);
        chk ("to late ldata", t_load_data, 32'h0);
        chkb("to late req", t_req, 1'b0);
        chkb("main nogrant req", mem_req, 1'b1);

        // Reset during REQ drops the request on the next edge
        do_reset();
        #1;
        chkb("rstreq req", mem_req, 1'b0);
        chkb("rstreq stall", stall, 1'b0);
        tick();

        // Reset during WAIT, then a late valid must be ignored
        issue(1'b1, OP_LW, 32'h0000_0200, 32'h0);
        tick();
        iMEM    = 1'b0;
        iMemGnt = 1'b1;
        #1;
        chkb("rstwait req c1", mem_req, 1'b1);
        tick();
        iMemGnt = 1'b0;
        #1;
        chkb("rstwait stall c2", stall, 1'b1);
        iRST = 1'b1;
        tick();
        iRST      = 1'b0;
        iMemValid = 1'b1;
        iMemRDATA = 32'h5555_AAAA;
        #1;
        chkb("rstwait req c3", mem_req, 1'b0);
        chkb("rstwait stall c3", stall, 1'b0);
        tick();
        iMemValid = 1'b0;
        #1;
        chkb("rstwait lvalid c4", load_valid, 1'b0);
        chk ("rstwait ldata c4", load_data, 32'h0);
        store_fast("swpost", OP_SW, 32'h0000_0104, 32'h55AA_55AA, 32'h0000_0104, 4'b1111, 32'h55AA_55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
